// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle RV32I ops plus iterative RV32M multiply/divide.
// busy stalls the pipeline while a multi-cycle op runs; done pulses when result updates.
module alu_exec_unit #(
  parameter int DATA_W   = 32,
  parameter bit M_ENABLE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              flush,
  input  logic [2:0]        alu_op,
  input  logic [6:0]        funct7,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  localparam int SW = $clog2(DATA_W);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0101;
  localparam logic [3:0] OP_BEQ = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1100;
  localparam logic [3:0] OP_SRL = 4'b1101;
  localparam logic [3:0] OP_SRA = 4'b1110;

  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  logic [1:0]          state;
  logic [3:0]          op;
  logic                is_m;
  logic [DATA_W-1:0]   base_res;
  logic [SW-1:0]       shamt;

  logic                m_sa, m_sb, m_div;
  logic                div_zero, div_ovf;
  logic [DATA_W-1:0]   fast_res;
  logic [DATA_W-1:0]   a_mag, b_mag;

  logic [2:0]          mf3;
  logic                neg_a, neg_b;
  logic [2*DATA_W-1:0] mcand, prod, prod_s;
  logic [DATA_W-1:0]   mplier;
  logic [DATA_W-1:0]   rem, quo, dvsr;
  logic [SW-1:0]       step;
  logic [DATA_W:0]     div_shift, div_diff;
  logic [DATA_W-1:0]   fin_res;

  assign busy  = (state != IDLE);
  assign shamt = src_b[SW-1:0];

  // Control decode from ALUOp/funct fields
  always_comb begin
    op   = OP_AND;
    is_m = 1'b0;
    case (alu_op)
      3'b000: op = OP_ADD;
      3'b001: op = OP_BEQ;
      3'b010, 3'b011: begin
        case (funct3)
          3'b000: begin
            if (alu_op == 3'b011 || funct7 == 7'b0000000) op = OP_ADD;
            else if (funct7 == 7'b0100000)                 op = OP_SUB;
            else                                           op = OP_AND;
          end
          3'b111: op = OP_AND;
          3'b110: op = OP_OR;
          3'b100: op = OP_XOR;
          3'b001: op = OP_SLL;
          3'b101: begin
            if (funct7 == 7'b0000000)      op = OP_SRL;
            else if (funct7 == 7'b0100000) op = OP_SRA;
            else                           op = OP_AND;
          end
          default: op = OP_AND;
        endcase
      end
      3'b100: begin
        if (M_ENABLE) is_m = 1'b1;
        else          op   = OP_ADD;
      end
      default: op = OP_AND;
    endcase
  end

  always_comb begin
    case (op)
      OP_AND:         base_res = src_a & src_b;
      OP_OR:          base_res = src_a | src_b;
      OP_XOR:         base_res = src_a ^ src_b;
      OP_ADD:         base_res = src_a + src_b;
      OP_SUB, OP_BEQ: base_res = src_a - src_b;
      OP_SLL:         base_res = src_a << shamt;
      OP_SRL:         base_res = src_a >> shamt;
      OP_SRA:         base_res = $signed(src_a) >>> shamt;
      default:        base_res = src_a & src_b;
    endcase
  end

  // M-extension operand prep and the divide corner cases that bypass iteration
  always_comb begin
    m_sa     = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    m_sb     = (funct3 == 3'b000) || (funct3 == 3'b001) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    m_div    = funct3[2];
    a_mag    = (m_sa && src_a[DATA_W-1]) ? -src_a : src_a;
    b_mag    = (m_sb && src_b[DATA_W-1]) ? -src_b : src_b;
    div_zero = (src_b == '0);
    div_ovf  = !funct3[0] && (src_a == MOST_NEG) && (src_b == '1);
    fast_res = '0;
    if (div_zero)     fast_res = funct3[1] ? src_a : '1;
    else if (div_ovf) fast_res = funct3[1] ? '0 : src_a;
  end

  always_comb begin
    div_shift = {rem, quo[DATA_W-1]};
    div_diff  = div_shift - {1'b0, dvsr};
  end

  always_comb begin
    prod_s = (neg_a ^ neg_b) ? -prod : prod;
    case (mf3)
      3'b000:                 fin_res = prod_s[DATA_W-1:0];
      3'b001, 3'b010, 3'b011: fin_res = prod_s[2*DATA_W-1:DATA_W];
      3'b100, 3'b101:         fin_res = (neg_a ^ neg_b) ? -quo : quo;
      default:                fin_res = neg_a ? -rem : rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      done   <= 1'b0;
      result <= '0;
      zero   <= 1'b0;
      mf3    <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      rem    <= '0;
      quo    <= '0;
      dvsr   <= '0;
      step   <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (!is_m) begin
                result <= base_res;
                zero   <= (base_res == '0);
                done   <= 1'b1;
              end else if (m_div && (div_zero || div_ovf)) begin
                result <= fast_res;
                zero   <= (fast_res == '0);
                done   <= 1'b1;
              end else begin
                mf3    <= funct3;
                neg_a  <= m_sa && src_a[DATA_W-1];
                neg_b  <= m_sb && src_b[DATA_W-1];
                mcand  <= {{DATA_W{1'b0}}, a_mag};
                mplier <= b_mag;
                prod   <= '0;
                rem    <= '0;
                quo    <= a_mag;
                dvsr   <= b_mag;
                step   <= '0;
                state  <= m_div ? DIV : MUL;
              end
            end
          end
          MUL: begin
            prod   <= prod + (mplier[0] ? mcand : '0);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            step   <= step + SW'(1);
            if (step == SW'(DATA_W - 1)) state <= FIN;
          end
          DIV: begin
            if (!div_diff[DATA_W]) begin
              rem <= div_diff[DATA_W-1:0];
              quo <= {quo[DATA_W-2:0], 1'b1};
            end else begin
              rem <= div_shift[DATA_W-1:0];
              quo <= {quo[DATA_W-2:0], 1'b0};
            end
            step <= step + SW'(1);
            if (step == SW'(DATA_W - 1)) state <= FIN;
          end
          FIN: begin
            result <= fin_res;
            zero   <= (fin_res == '0);
            done   <= 1'b1;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit (DATA_W=32): base ops, multiply/divide, corners, flush, reset.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  alu_op = '0;
  logic [6:0]  funct7 = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        busy, done, zero;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.DATA_W(32), .M_ENABLE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
    .alu_op(alu_op), .funct7(funct7), .funct3(funct3),
    .src_a(src_a), .src_b(src_b),
    .busy(busy), .done(done), .result(result), .zero(zero)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b);
    alu_op = op; funct7 = f7; funct3 = f3; src_a = a; src_b = b;
  endtask

  // Issue one op, wait (bounded) for done, check result, zero, latency and busy cycles.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [6:0] f7,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat);
    int cyc;
    int busy_cyc;
    @(negedge clk);
    drive(op, f7, f3, a, b);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    busy_cyc = busy ? 1 : 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cyc++;
    end
    check({tag, "/result"}, result, exp);
    check({tag, "/zero"}, 32'(zero), 32'(exp == 32'h0));
    check({tag, "/latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, "/busy_cycles"}, 32'(busy_cyc), 32'(exp_lat - 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int ndone;

    repeat (3) @(negedge clk);
    check("reset/busy", 32'(busy), 32'h0);
    check("reset/done", 32'(done), 32'h0);
    check("reset/result", result, 32'h0);
    check("reset/zero", 32'(zero), 32'h0);
    rst_n = 1'b1;

    // Base ops
    run_op("sub", 3'b010, 7'b0100000, 3'b000, 32'd3, 32'd5, 32'hFFFF_FFFE, 1);
    run_op("sra", 3'b010, 7'b0100000, 3'b101, 32'h8000_0000, 32'd4, 32'hF800_0000, 1);
    run_op("srl", 3'b010, 7'b0000000, 3'b101, 32'h8000_0000, 32'd4, 32'h0800_0000, 1);
    run_op("srai", 3'b011, 7'b0100000, 3'b101, 32'hF000_0000, 32'd8, 32'hFFF0_0000, 1);
    run_op("sll_shamt", 3'b010, 7'b0000000, 3'b001, 32'h1, 32'h0000_0024, 32'h10, 1);
    run_op("beq_eq", 3'b001, 7'b0, 3'b000, 32'h1234, 32'h1234, 32'h0, 1);
    run_op("undef_and", 3'b010, 7'b0, 3'b010, 32'hC, 32'hA, 32'h8, 1);
    run_op("xor", 3'b010, 7'b0000000, 3'b100, 32'hF0F0, 32'h0FF0, 32'hFF00, 1);

    // Reset mid-divide
    @(negedge clk);
    drive(3'b100, 7'b0000001, 3'b101, 32'd100, 32'd7);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("rstdiv/busy_before", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rstdiv/busy", 32'(busy), 32'h0);
    check("rstdiv/done", 32'(done), 32'h0);
    check("rstdiv/result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("add_after_rst", 3'b000, 7'b0, 3'b000, 32'd5, 32'd7, 32'd12, 1);

    // Multiply
    run_op("mul", 3'b100, 7'b0000001, 3'b000, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 34);
    run_op("mulh", 3'b100, 7'b0000001, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 34);
    run_op("mulhu", 3'b100, 7'b0000001, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run_op("mulhsu", 3'b100, 7'b0000001, 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34);

    // Divide
    run_op("div", 3'b100, 7'b0000001, 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run_op("rem", 3'b100, 7'b0000001, 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run_op("divu", 3'b100, 7'b0000001, 3'b101, 32'd100, 32'd7, 32'd14, 34);
    run_op("remu", 3'b100, 7'b0000001, 3'b111, 32'd100, 32'd7, 32'd2, 34);

    // Divide corner cases
    run_op("div_by0", 3'b100, 7'b0000001, 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu_by0", 3'b100, 7'b0000001, 3'b111, 32'd5, 32'd0, 32'd5, 1);
    run_op("div_ovf", 3'b100, 7'b0000001, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf", 3'b100, 7'b0000001, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

    // Flush mid-multiply
    run_op("add_pre_flush", 3'b000, 7'b0, 3'b000, 32'd1, 32'd2, 32'd3, 1);
    @(negedge clk);
    drive(3'b100, 7'b0000001, 3'b000, 32'd3, 32'd5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush/busy", 32'(busy), 32'h0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("flush/no_done", 32'(ndone), 32'h0);
    check("flush/result_kept", result, 32'd3);

    // Flush and start together in IDLE: start dropped
    drive(3'b000, 7'b0, 3'b000, 32'd7, 32'd7);
    start = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    check("flush_start/done", 32'(done), 32'h0);
    check("flush_start/result", result, 32'd3);

    // Start pulse while busy is ignored
    @(negedge clk);
    drive(3'b100, 7'b0000001, 3'b000, 32'd3, 32'd5);
    start = 1'b1;
    cyc = 0;
    while (cyc == 0 || (!done && cyc < 100)) begin
      @(negedge clk);
      cyc++;
      start = (cyc == 5);
    end
    start = 1'b0;
    check("busy_start/latency", 32'(cyc), 32'd34);
    check("busy_start/result", result, 32'd15);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("busy_start/extra_done", 32'(ndone), 32'h0);

    // Back-to-back: ADD issued in the cycle done is seen
    drive(3'b100, 7'b0000001, 3'b000, 32'd7, 32'd6);
    start = 1'b1;
    cyc = 0;
    while (cyc == 0 || (!done && cyc < 100)) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
    end
    check("b2b/mul_result", result, 32'd42);
    check("b2b/mul_latency", 32'(cyc), 32'd34);
    drive(3'b000, 7'b0, 3'b000, 32'd10, 32'd20);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b/add_done", 32'(done), 32'h1);
    check("b2b/add_result", result, 32'd30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised execute-stage ALU that decodes the control fields itself, from ALUOp, Funct7 and Funct3.
- Runs base RV32I ALU ops in one cycle.
- Adds iterative RV32M multiply/divide with a start/done handshake and a busy signal that stalls the pipeline.
- Sits in EX, fed by the ID/EX register. The hazard unit uses busy to freeze IF/ID/EX.

Parameters:
- DATA_W, 32, operand/result width (any value ≥ 8).
- M_ENABLE, 1, 1 = multiply/divide implemented; 0 = M ops decode as ADD and finish in 1 cycle.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  accept a new operation (sampled only when busy=0).
- flush  in  1  abort the in-flight operation (pipeline flush).
- alu_op  in  3  000 load/store/AUIPC, 001 branch, 010 R-type, 011 I-type, 100 M-type.
- funct7  in  7  instruction bits 31:25.
- funct3  in  3  instruction bits 14:12.
- src_a  in  DATA_W  operand A.
- src_b  in  DATA_W  operand B (immediate already muxed).
- busy  out  1  multi-cycle op in progress; stall upstream.
- done  out  1  one-cycle pulse: result valid.
- result  out  DATA_W  registered result; held until the next done.
- zero  out  1  registered (result == 0), updated with result.

Behaviour:
- Reset: asserting rst_n low immediately clears result, zero, done, busy and all datapath registers, and sets state=IDLE. Reset mid-operation discards the operation.
- Decode (combinational, inside the block):
  - Internal op code: 0000 AND, 0001 OR, 0010 XOR, 0100 ADD, 0101 SUB, 1000 branch SUB-compare, 1100 SLL, 1101 SRL, 1110 SRA.
  - alu_op 000: ADD.
  - alu_op 001: SUB-compare; zero reflects src_a == src_b.
  - alu_op 010 (R-type):
    - f3 000 → ADD/SUB by funct7 (0000000 / 0100000).
    - 111 → AND; 110 → OR; 100 → XOR.
    - 001 → SLL; 101 → SRL/SRA by funct7.
  - alu_op 011 (I-type): f3 000 ADDI, 111 ANDI, 110 ORI, 100 XORI, 001 SLLI, 101 SRLI/SRAI.
  - alu_op 100 (M-type): funct3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
  - Any unlisted combination → AND (0000).
  - Shift amount is src_b[$clog2(DATA_W)-1:0].
- States: IDLE, MUL, DIV, FIN.
- IDLE with start=1:
  - Base op: result/zero registered at the next edge, done=1 that cycle, state stays IDLE. Latency 1, busy never asserts.
  - MUL/DIV op: operands are latched as magnitudes; the signedness of each operand is latched per funct3. State goes to MUL or DIV, busy=1 from the next cycle.
- MUL:
  - Shift-add, one multiplier bit per cycle.
  - Step counter runs 0..DATA_W-1 and builds a 2*DATA_W-bit product. Then → FIN.
- DIV:
  - Restoring divide, one quotient bit per cycle, DATA_W cycles. Then → FIN.
- FIN:
  - Sign correction: product negated if signs differ. Quotient negated if signs differ; remainder takes the dividend's sign.
  - Select low half (MUL), high half (MULH*), quotient or remainder.
  - Register result/zero, done=1 for one cycle, busy=0, → IDLE.
  - Total latency from start to done = DATA_W+2 cycles; busy is high for DATA_W+1 of them.
- Divide corner cases (fast path, latency 1, no busy):
  - Divisor == 0: DIV/DIVU quotient = all ones; REM/REMU = dividend.
  - Signed overflow (src_a = most negative, src_b = all ones): DIV = src_a, REM = 0.
- start while busy=1 is ignored; the operands must be held by the stall.
- flush=1 has priority over everything except reset:
  - Forces state=IDLE and busy=0 next cycle; no done for the aborted op.
  - result keeps its prior value.
  - flush and start in the same IDLE cycle: start is dropped.
- done and start may coincide: a new start is accepted in the cycle after FIN, because busy is already 0 in FIN's next cycle.
- M_ENABLE=0: no MUL/DIV states are synthesised; alu_op 100 executes as ADD.

Test Plan:
- Reset asserted mid-DIV (cycle 10) → busy/done/result immediately 0, state IDLE; the next ADD 5+7 gives result=12 at latency 1.
- R-type sweep, DATA_W=32:
  - SUB 3-5 → 0xFFFFFFFE.
  - SRA 0x80000000 by 4 → 0xF8000000.
  - SRL 0x80000000 by 4 → 0x08000000.
  - XOR 0xF0F0 ^ 0x0FF0 → 0xFF00.
  - All at 1-cycle latency.
- Multiply:
  - MUL 0xFFFFFFFF × 2 → 0xFFFFFFFE.
  - MULH -1 × -1 → 0x0.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU -1 × 2 → 0xFFFFFFFF.
  - In each case done arrives exactly 34 cycles after start, and busy is high for 33 cycles.
- Divide:
  - DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU 100/7 → 2.
  - Latency 34.
- Corner cases:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/-1 → 0x80000000; REM → 0.
  - All at latency 1 with zero set on the REM case.
- Flush at cycle 5 of a MUL → busy drops next cycle, no done, result unchanged.
- A start pulse during busy is ignored.
- Back-to-back MUL then ADD: the ADD start accepted the cycle after done gives its done one cycle later.
